shift_rows_stream: RTL and testbench

//  Parametrised, pipelined ShiftRows/InvShiftRows unit for the AES/Rijndael datapath.
//  One instance serves both the encrypt and decrypt round: the direction is selected per beat.
//  The state width is generalised to Rijndael block sizes NB = 4/6/8 columns.

---
 rtl/shift_rows_stream.sv | 107 ++++++++++
 tb/tb_shift_rows_stream.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_stream.sv
// rtl/shift_rows_stream.sv - pipelined ShiftRows/InvShiftRows for Rijndael NB = 4/6/8
// Direction is chosen per beat; tag rides alongside the state through every slot.
module shift_rows_stream #(
   parameter int NB     = 4,
   parameter int STAGES = 1,
   parameter int TAGW   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_inv,
   input  logic [32*NB-1:0]  in_state,
   input  logic [TAGW-1:0]   in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  out_state,
   output logic [TAGW-1:0]   out_tag,
   output logic [1:0]        occupancy
);
   localparam int W = 32 * NB;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_stream: NB must be 4, 6 or 8");
   end
   if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $error("shift_rows_stream: STAGES must be 1..3");
   end

   logic [W-1:0] xf_state;

   // Byte (r,c) lives at [W-1-8*(4c+r) -: 8]; NB=8 uses offsets 1,3,4 for rows 1..3.
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S = (r == 0) ? 0 : ((NB == 8 && r >= 2) ? r + 1 : r);
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int FC = (c + S) % NB;
         localparam int IC = (c + NB - S) % NB;
         assign xf_state[W-1-8*(4*c+r) -: 8] = in_inv ? in_state[W-1-8*(4*IC+r) -: 8]
                                                      : in_state[W-1-8*(4*FC+r) -: 8];
      end
   end

   logic [STAGES-1:0] v;
   logic [W-1:0]      st [STAGES];
   logic [TAGW-1:0]   tg [STAGES];
   logic [STAGES-1:0] rdy;
   logic              nxt;
   logic [STAGES-1:0] src_v;
   logic [W-1:0]      src_st [STAGES];
   logic [TAGW-1:0]   src_tg [STAGES];

   // A slot can load if it is empty or its occupant leaves this cycle.
   always_comb begin
      nxt = out_ready;
      rdy = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         nxt    = !v[k] | nxt;
         rdy[k] = nxt;
      end
   end

   always_comb begin
      src_v     = '0;
      src_v[0]  = in_valid;
      src_st[0] = xf_state;
      src_tg[0] = in_tag;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k]  = v[k-1];
         src_st[k] = st[k-1];
         src_tg[k] = tg[k-1];
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v[STAGES-1];
   assign out_state = st[STAGES-1];
   assign out_tag   = tg[STAGES-1];

   logic acc, emit;
   assign acc  = in_valid & rdy[0];
   assign emit = v[STAGES-1] & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v         <= '0;
         occupancy <= 2'd0;
         for (int k = 0; k < STAGES; k++) begin
            st[k] <= '0;
            tg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               v[k] <= src_v[k];
               if (src_v[k]) begin
                  st[k] <= src_st[k];
                  tg[k] <= src_tg[k];
               end
            end
         end
         if (acc && !emit && occupancy != 2'd3)
            occupancy <= occupancy + 2'd1;
         else if (emit && !acc && occupancy != 2'd0)
            occupancy <= occupancy - 2'd1;
      end
   end
endmodule

// File: tb/tb_shift_rows_stream.sv
// tb/tb_shift_rows_stream.sv - scoreboard bench for shift_rows_stream
// Main unit NB=4/STAGES=3; side units NB=8/STAGES=1 and NB=6/STAGES=2.
module tb_shift_rows_stream;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, in_inv, out_valid, out_ready;
   logic [127:0] in_state, out_state;
   logic [3:0]   in_tag, out_tag;
   logic [1:0]   occupancy;

   logic         a8_valid, a8_ready, a8_inv, a8_ov;
   logic [255:0] a8_state, a8_os;
   logic [3:0]   a8_otag;
   logic [1:0]   a8_occ;
   logic         a6_valid, a6_ready, a6_inv, a6_ov;
   logic [191:0] a6_state, a6_os;
   logic [3:0]   a6_otag;
   logic [1:0]   a6_occ;
   logic [3:0]   tag_c = 4'h5;
   logic         one   = 1'b1;

   shift_rows_stream #(.NB(4), .STAGES(3), .TAGW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
      .in_state(in_state), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_state(out_state), .out_tag(out_tag), .occupancy(occupancy));

   shift_rows_stream #(.NB(8), .STAGES(1), .TAGW(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(a8_valid), .in_ready(a8_ready), .in_inv(a8_inv),
      .in_state(a8_state), .in_tag(tag_c), .out_valid(a8_ov), .out_ready(one),
      .out_state(a8_os), .out_tag(a8_otag), .occupancy(a8_occ));

   shift_rows_stream #(.NB(6), .STAGES(2), .TAGW(4)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(a6_valid), .in_ready(a6_ready), .in_inv(a6_inv),
      .in_state(a6_state), .in_tag(tag_c), .out_valid(a6_ov), .out_ready(one),
      .out_state(a6_os), .out_tag(a6_otag), .occupancy(a6_occ));

   localparam logic [127:0] A  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] B  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [255:0] I8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] O8 = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
   localparam logic [191:0] I6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [191:0] O6 = 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b;

   typedef struct {
      logic [127:0] st;
      logic [3:0]   tg;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t         q[$];
   logic [255:0] q8[$];
   logic [191:0] q6[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc = 0;
   bit           rnd_en = 0;
   bit           hold_f = 0;
   logic [127:0] hold_st;
   logic [3:0]   hold_tg;
   exp_t         e;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] ref_fwd(input logic [127:0] x);
      logic [7:0]   b[4][4];
      logic [127:0] y;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[r][c] = x[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            y[127-8*(4*c+r) -: 8] = b[r][(c+r)%4];
      return y;
   endfunction

   always @(posedge clk) if (rnd_en) begin
      #1 out_ready = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) if (rst_n) begin
      if (hold_f) begin
         check("hold_valid", 256'(out_valid), 256'd1);
         check("hold_state", 256'(out_state), 256'(hold_st));
         check("hold_tag", 256'(out_tag), 256'(hold_tg));
      end
      hold_f  = out_valid && !out_ready;
      hold_st = out_state;
      hold_tg = out_tag;
      if (occupancy == 2'd3 && !out_ready) check("full_in_ready", 256'(in_ready), 256'd0);
      if (out_valid && out_ready) begin
         if (q.size() == 0) check("extra_beat", 256'd1, 256'd0);
         else begin
            e = q.pop_front();
            check("out_state", 256'(out_state), 256'(e.st));
            check("out_tag", 256'(out_tag), 256'(e.tg));
            if (e.lat) check("latency", 256'(cyc - e.acc), 256'd3);
         end
      end
      if (a8_ov) begin
         if (q8.size() == 0) check("nb8_extra", 256'd1, 256'd0);
         else check("nb8_state", a8_os, q8.pop_front());
      end
      if (a6_ov) begin
         if (q6.size() == 0) check("nb6_extra", 256'd1, 256'd0);
         else check("nb6_state", 256'(a6_os), 256'(q6.pop_front()));
      end
   end

   task automatic send(input bit inv, input logic [127:0] st, input logic [3:0] tg,
                       input logic [127:0] exp, input bit lat, output int waits);
      bit ok = 0;
      in_valid = 1'b1; in_inv = inv; in_state = st; in_tag = tg; waits = 0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            q.push_back('{exp, tg, cyc, lat});
         end else waits++;
         @(posedge clk); #1;
      end
      if (!ok) check("send_timeout", 256'd0, 256'd1);
   endtask

   task automatic send8(input bit inv, input logic [255:0] st, input logic [255:0] exp);
      a8_valid = 1'b1; a8_inv = inv; a8_state = st;
      @(negedge clk);
      check("nb8_in_ready", 256'(a8_ready), 256'd1);
      q8.push_back(exp);
      @(posedge clk); #1;
      a8_valid = 1'b0;
   endtask

   task automatic send6(input bit inv, input logic [191:0] st, input logic [191:0] exp);
      a6_valid = 1'b1; a6_inv = inv; a6_state = st;
      @(negedge clk);
      check("nb6_in_ready", 256'(a6_ready), 256'd1);
      q6.push_back(exp);
      @(posedge clk); #1;
      a6_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 500 && (q.size() + q8.size() + q6.size()) != 0; n++) @(posedge clk);
      #1;
      check("drain_empty", 256'(q.size() + q8.size() + q6.size()), 256'd0);
   endtask

   initial begin
      int w;
      logic [127:0] x, f;
      rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_state = '0; in_tag = '0; out_ready = 1'b1;
      a8_valid = 1'b0; a8_inv = 1'b0; a8_state = '0; a6_valid = 1'b0; a6_inv = 1'b0; a6_state = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 256'(out_valid), 256'd0);
      check("rst_out_state", 256'(out_state), 256'd0);
      check("rst_out_tag", 256'(out_tag), 256'd0);
      check("rst_occupancy", 256'(occupancy), 256'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 256'(in_ready), 256'd1);
      @(posedge clk); #1;

      send(1'b0, A, 4'h1, B, 1'b1, w);
      in_valid = 1'b0;
      send8(1'b0, I8, O8);
      send6(1'b0, I6, O6);
      send(1'b1, B, 4'h2, A, 1'b1, w);
      in_valid = 1'b0;
      send8(1'b1, O8, I8);
      send6(1'b1, O6, I6);
      drain();

      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 1) send(1'b1, B, 4'(i), A, 1'b1, w);
         else            send(1'b0, A, 4'(i), B, 1'b1, w);
         check("b2b_no_wait", 256'(w), 256'd0);
      end
      in_valid = 1'b0;
      drain();

      rnd_en = 1;
      for (int i = 0; i < 200; i++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         f = ref_fwd(x);
         if ($urandom_range(0, 1) == 0) send(1'b0, x, 4'(i), f, 1'b0, w);
         else                           send(1'b1, f, 4'(i), x, 1'b0, w);
      end
      in_valid = 1'b0;
      rnd_en = 0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      drain();

      send(1'b0, A, 4'h3, B, 1'b1, w);
      send(1'b1, B, 4'h4, A, 1'b1, w);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 256'(out_valid), 256'd0);
      check("midrst_occupancy", 256'(occupancy), 256'd0);
      check("midrst_out_state", 256'(out_state), 256'd0);
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(1'b0, A, 4'h9, B, 1'b1, w);
      in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
